// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare direction predictor.
package gshare_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Weakly-not-taken value for a counter of ctr_bits bits; taken iff ctr > this.
  function automatic logic [31:0] ctr_wnt(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic logic [31:0] ctr_sat_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int unsigned ctr_bits);
    logic [31:0] max_ctr;
    max_ctr = (32'd1 << ctr_bits) - 32'd1;
    if (taken) begin
      return (ctr >= max_ctr) ? max_ctr : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_pht_ram.sv
// Pattern history table storage: one write port, one registered read port, read-first.
module gshare_pht_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read in the same edge; a colliding read sees the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gshare_spec_predictor.sv
// Gshare direction predictor with speculative global history and init sweep.
module gshare_spec_predictor
  import gshare_pkg::*;
#(
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned HIST_BITS   = 8,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned PC_LSB      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [31:0]                    predict_addr,
  output logic                           predict_taken,
  output logic [CTR_BITS-1:0]            predict_ctr,
  output logic [$clog2(PHT_ENTRIES)-1:0] predict_idx,
  output logic [HIST_BITS-1:0]           predict_hist,
  output logic                           ready,
  input  logic                           spec_push,
  input  logic                           spec_taken,
  input  logic                           update_valid,
  input  logic [$clog2(PHT_ENTRIES)-1:0] update_idx,
  input  logic [CTR_BITS-1:0]            update_ctr,
  input  logic [HIST_BITS-1:0]           update_hist,
  input  logic                           update_taken,
  input  logic                           update_mispred
);

  localparam int unsigned IDXW = $clog2(PHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

  state_t              state;
  state_t              state_nxt;
  logic [IDXW-1:0]     sweep_cnt;
  logic                sweep_last;
  logic [HIST_BITS-1:0] spec_ghr;
  logic [IDXW-1:0]     lookup_idx;
  logic                pht_we;
  logic [IDXW-1:0]     pht_waddr;
  logic [CTR_BITS-1:0] pht_wdata;
  logic [CTR_BITS-1:0] pht_rdata;
  logic                byp_hit_q;
  logic [CTR_BITS-1:0] byp_ctr_q;
  logic                unused_bits;

  assign sweep_last  = (sweep_cnt == IDXW'(PHT_ENTRIES - 1));
  assign lookup_idx  = predict_addr[PC_LSB +: IDXW] ^ IDXW'(spec_ghr);
  assign unused_bits = ^{predict_addr, update_hist};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Leave INIT once the last PHT entry has been swept.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Sweep address and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
      ready     <= 1'b0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + IDXW'(1);
      if (sweep_last) begin
        ready <= 1'b1;
      end
    end
  end

  // PHT write port: sweep writes WNT during INIT, resolved branches train in RUN.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = update_idx;
    pht_wdata = CTR_BITS'(ctr_sat_next(32'(update_ctr), update_taken, CTR_BITS));
    if (rst) begin
      pht_we = 1'b0;
    end else if (state == INIT) begin
      pht_we    = 1'b1;
      pht_waddr = sweep_cnt;
      pht_wdata = WNT;
    end else if (update_valid) begin
      pht_we = 1'b1;
    end
  end

  gshare_pht_ram #(
    .DEPTH  (PHT_ENTRIES),
    .ADDR_W (IDXW),
    .DATA_W (CTR_BITS)
  ) u_pht (
    .clk   (clk),
    .we    (pht_we),
    .waddr (pht_waddr),
    .wdata (pht_wdata),
    .re    (!stall),
    .raddr (lookup_idx),
    .rdata (pht_rdata)
  );

  // Lookup pipeline register; bypass captures a same-cycle write to the looked-up entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      predict_idx  <= '0;
      predict_hist <= '0;
      byp_hit_q    <= 1'b1;
      byp_ctr_q    <= WNT;
    end else if (!stall) begin
      predict_idx  <= lookup_idx;
      predict_hist <= spec_ghr;
      byp_hit_q    <= pht_we && (pht_waddr == lookup_idx);
      byp_ctr_q    <= pht_wdata;
    end
  end

  // Speculative history: mispredict repair has priority over a fetch push.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr <= '0;
    end else if (state == RUN) begin
      if (update_valid && update_mispred) begin
        spec_ghr <= HIST_BITS'({update_hist, update_taken});
      end else if (spec_push) begin
        spec_ghr <= HIST_BITS'({spec_ghr, spec_taken});
      end
    end
  end

  assign predict_ctr   = byp_hit_q ? byp_ctr_q : pht_rdata;
  assign predict_taken = ready && (predict_ctr > WNT);

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Self-checking bench for gshare_spec_predictor (default parameters).
module tb_gshare_spec_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] predict_addr;
  logic        predict_taken;
  logic [1:0]  predict_ctr;
  logic [7:0]  predict_idx;
  logic [7:0]  predict_hist;
  logic        ready;
  logic        spec_push;
  logic        spec_taken;
  logic        update_valid;
  logic [7:0]  update_idx;
  logic [1:0]  update_ctr;
  logic [7:0]  update_hist;
  logic        update_taken;
  logic        update_mispred;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] idx;
    logic [1:0] ctr;
    logic [7:0] hist;
    logic       taken;
  } look_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  idx;
  } lk_vec_t;

  typedef struct {
    logic [7:0] idx;
    logic [1:0] ctr;
    logic       taken;
    logic [1:0] exp_ctr;
    logic       exp_taken;
  } upd_vec_t;

  look_t    sb_q[$];
  lk_vec_t  lk_tab[6];
  upd_vec_t upd_tab[7];
  logic [7:0] wnt_idx[8];

  gshare_spec_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .predict_addr   (predict_addr),
    .predict_taken  (predict_taken),
    .predict_ctr    (predict_ctr),
    .predict_idx    (predict_idx),
    .predict_hist   (predict_hist),
    .ready          (ready),
    .spec_push      (spec_push),
    .spec_taken     (spec_taken),
    .update_valid   (update_valid),
    .update_idx     (update_idx),
    .update_ctr     (update_ctr),
    .update_hist    (update_hist),
    .update_taken   (update_taken),
    .update_mispred (update_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    spec_push      = 1'b0;
    spec_taken     = 1'b0;
    update_valid   = 1'b0;
    update_idx     = 8'h00;
    update_ctr     = 2'd0;
    update_hist    = 8'h00;
    update_taken   = 1'b0;
    update_mispred = 1'b0;
  endtask

  // Clock one edge and compare the oldest pending lookup expectation.
  task automatic clock_and_check(input string name);
    tick();
    if (sb_q.size() > 0) begin
      look_t e;
      e = sb_q.pop_front();
      check({name, ".idx"},   32'(predict_idx),   32'(e.idx));
      check({name, ".ctr"},   32'(predict_ctr),   32'(e.ctr));
      check({name, ".hist"},  32'(predict_hist),  32'(e.hist));
      check({name, ".taken"}, 32'(predict_taken), 32'(e.taken));
    end else begin
      check({name, ".sb_empty"}, 32'd0, 32'd1);
    end
  endtask

  // Unstalled lookup; update/push inputs are whatever the caller left set.
  task automatic look(input string name, input logic [31:0] addr, input logic [7:0] idx,
                      input logic [1:0] ctr, input logic [7:0] hist, input logic taken);
    look_t e;
    predict_addr = addr;
    stall        = 1'b0;
    e.idx = idx; e.ctr = ctr; e.hist = hist; e.taken = taken;
    sb_q.push_back(e);
    clock_and_check(name);
  endtask

  // One stalled cycle carrying an update.
  task automatic do_update(input logic [7:0] idx, input logic [1:0] ctr, input logic taken);
    stall        = 1'b1;
    update_valid = 1'b1;
    update_idx   = idx;
    update_ctr   = ctr;
    update_taken = taken;
    tick();
    idle_inputs();
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".ready"}, 32'(ready),         32'd0);
    check({name, ".taken"}, 32'(predict_taken), 32'd0);
    check({name, ".ctr"},   32'(predict_ctr),   32'd1);
    check({name, ".idx"},   32'(predict_idx),   32'd0);
    check({name, ".hist"},  32'(predict_hist),  32'd0);
  endtask

  // Count edges until ready while hammering ignored inputs; sweep lookups must say not-taken.
  task automatic sweep_to_ready(input string name, input logic noisy);
    int cycles;
    int taken_seen;
    cycles     = 0;
    taken_seen = 0;
    while (cycles < 1000) begin
      predict_addr = $urandom;
      if (noisy) begin
        spec_push    = 1'b1;
        spec_taken   = 1'b1;
        update_valid = 1'b1;
        update_idx   = 8'd150;
        update_ctr   = 2'd2;
        update_taken = 1'b1;
      end
      tick();
      cycles++;
      if (ready) break;
      if (predict_taken) taken_seen++;
    end
    idle_inputs();
    check({name, ".ready_latency"}, 32'(cycles),     32'd256);
    check({name, ".init_taken"},    32'(taken_seen), 32'd0);
  endtask

  initial begin
    lk_tab[0] = '{32'h0000_0000, 8'h00};
    lk_tab[1] = '{32'h0000_0014, 8'h05};
    lk_tab[2] = '{32'h0000_03FC, 8'hFF};
    lk_tab[3] = '{32'h0000_0400, 8'h00};
    lk_tab[4] = '{32'hFFFF_FFFF, 8'hFF};
    lk_tab[5] = '{32'h0000_0203, 8'h80};

    upd_tab[0] = '{8'd5, 2'd1, 1'b1, 2'd2, 1'b1};
    upd_tab[1] = '{8'd5, 2'd2, 1'b1, 2'd3, 1'b1};
    upd_tab[2] = '{8'd5, 2'd3, 1'b1, 2'd3, 1'b1};
    upd_tab[3] = '{8'd5, 2'd3, 1'b0, 2'd2, 1'b1};
    upd_tab[4] = '{8'd9, 2'd0, 1'b0, 2'd0, 1'b0};
    upd_tab[5] = '{8'd9, 2'd1, 1'b1, 2'd2, 1'b1};
    upd_tab[6] = '{8'd9, 2'd2, 1'b0, 2'd1, 1'b0};

    wnt_idx = '{8'd5, 8'd7, 8'd9, 8'h20, 8'd100, 8'd150, 8'd200, 8'd255};

    // Reset and first init sweep.
    idle_inputs();
    predict_addr = 32'h0;
    rst = 1'b1;
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    sweep_to_ready("init", 1'b0);

    // Fresh table: every entry weakly not-taken, ghr = 0.
    for (int i = 0; i < 6; i++) begin
      look($sformatf("wnt_lookup%0d", i), lk_tab[i].addr, lk_tab[i].idx, 2'd1, 8'h00, 1'b0);
    end

    // Counter training including both saturation limits.
    for (int i = 0; i < 7; i++) begin
      do_update(upd_tab[i].idx, upd_tab[i].ctr, upd_tab[i].taken);
      look($sformatf("train%0d", i), 32'(upd_tab[i].idx) << 2, upd_tab[i].idx,
           upd_tab[i].exp_ctr, 8'h00, upd_tab[i].exp_taken);
    end

    // Speculative history push and repair.
    for (int i = 0; i < 3; i++) begin
      stall      = 1'b1;
      spec_push  = 1'b1;
      spec_taken = 1'b1;
      tick();
    end
    idle_inputs();
    look("ghr_push3", 32'h0, 8'h07, 2'd1, 8'h07, 1'b0);
    stall          = 1'b1;
    update_valid   = 1'b1;
    update_mispred = 1'b1;
    update_hist    = 8'h01;
    update_taken   = 1'b0;
    update_idx     = 8'h20;
    update_ctr     = 2'd1;
    spec_push      = 1'b1;
    spec_taken     = 1'b1;
    tick();
    idle_inputs();
    look("ghr_repair", 32'h0, 8'h02, 2'd1, 8'h02, 1'b0);
    stall          = 1'b1;
    update_mispred = 1'b1;
    update_hist    = 8'hAA;
    update_taken   = 1'b1;
    tick();
    idle_inputs();
    look("mispred_no_valid", 32'h0, 8'h02, 2'd1, 8'h02, 1'b0);
    look("repair_trained", 32'h88, 8'h20, 2'd0, 8'h02, 1'b0);

    // Hash with history and stall hold.
    look("hash_pc14", 32'h14, 8'h07, 2'd1, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stall        = 1'b1;
      predict_addr = 32'h100 * (i + 1);
      tick();
      check($sformatf("stall%0d.idx", i), 32'(predict_idx), 32'h07);
      check($sformatf("stall%0d.ctr", i), 32'(predict_ctr), 32'd1);
    end
    idle_inputs();

    // Write-first bypass on a same-cycle update to the looked-up entry.
    update_valid = 1'b1;
    update_idx   = 8'h07;
    update_ctr   = 2'd1;
    update_taken = 1'b1;
    look("bypass_inc", 32'h14, 8'h07, 2'd2, 8'h02, 1'b1);
    idle_inputs();
    stall        = 1'b1;
    predict_addr = 32'h14;
    update_valid = 1'b1;
    update_idx   = 8'h07;
    update_ctr   = 2'd2;
    update_taken = 1'b1;
    tick();
    idle_inputs();
    check("stall_no_bypass.ctr", 32'(predict_ctr), 32'd2);
    look("after_stall_write", 32'h14, 8'h07, 2'd3, 8'h02, 1'b1);

    // Fill high entries, then restart the sweep part-way through.
    do_update(8'd150, 2'd2, 1'b1);
    do_update(8'd200, 2'd1, 1'b0);
    do_update(8'd255, 2'd2, 1'b1);
    look("prefill150", 32'h250, 8'd150, 2'd3, 8'h02, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      predict_addr = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    check_reset_state("midsweep_reset");
    rst = 1'b0;
    sweep_to_ready("resweep", 1'b1);
    for (int i = 0; i < 8; i++) begin
      look($sformatf("resweep_wnt%0d", i), 32'(wnt_idx[i]) << 2, wnt_idx[i], 2'd1, 8'h00, 1'b0);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
